cp0_unit: RTL



---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and Status/Cause bit positions.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_BEV    = 22;

    localparam int CA_BD     = 31;
    localparam int CA_TI     = 30;
    localparam int CA_IP_LO  = 8;
    localparam int CA_EXC_LO = 2;

    // Status bits software may change: BEV, IM[7:0], EXL, IE
    localparam logic [31:0] STATUS_WR_MASK = 32'h0040_FF03;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI is sticky until Compare is written.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick;
    logic        count_wr;
    logic        compare_wr;
    logic [31:0] count_inc;

    assign count_wr   = wr_en && (wr_addr == REG_COUNT);
    assign compare_wr = wr_en && (wr_addr == REG_COMPARE);
    assign count_inc  = count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            tick    <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (count_wr) begin
                count <= wr_data;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    count <= count_inc;
            end

            // A Compare write acknowledges the timer and wins over a same-edge match
            if (compare_wr) begin
                compare <= wr_data;
                ti      <= 1'b0;
            end else if (tick && !count_wr && (count_inc == compare) && (compare != 32'd0)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: exception/interrupt arbitration, flush/redirect, CP0 register file.
// Optional timer (Count/Compare/TI) is built when CP0_TIMER_EN is defined.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_FF00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            rd_addr_i,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [4:0]            wr_addr_i,
    input  logic [31:0]           wr_data_i,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  inst_valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  delayslot_i,
    input  logic [31:0]           badvaddr_i,
    input  logic                  adel_if_i,
    input  logic                  ri_i,
    input  logic                  ov_i,
    input  logic                  sys_i,
    input  logic                  bp_i,
    input  logic                  adel_i,
    input  logic                  ades_i,
    input  logic                  eret_i,
    output logic                  flush_o,
    output logic [31:0]           new_pc_o,
    output logic                  int_pending_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic        bd_q;
    exc_code_e   exccode_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic [5:0]  hw_ext;
    logic [7:0]  ip;
    logic        int_take;
    logic        exc_take;
    exc_code_e   exc_code;
    logic        exc_badaddr;
    logic        wr_ok;

    always_comb begin
        hw_ext = '0;
        hw_ext[NUM_HW_INT-1:0] = hw_int_i;
    end

    assign ip            = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign int_pending_o = status_q[ST_IE] & ~status_q[ST_EXL] & (|(ip & status_q[ST_IM_LO +: 8]));
    assign int_take      = int_pending_o & inst_valid_i;

    always_comb begin
        exc_take    = 1'b1;
        exc_code    = EXC_INT;
        exc_badaddr = 1'b0;
        if (int_take) begin
            exc_code = EXC_INT;
        end else if (adel_if_i) begin
            exc_code    = EXC_ADEL;
            exc_badaddr = 1'b1;
        end else if (ri_i) begin
            exc_code = EXC_RI;
        end else if (ov_i) begin
            exc_code = EXC_OV;
        end else if (sys_i) begin
            exc_code = EXC_SYS;
        end else if (bp_i) begin
            exc_code = EXC_BP;
        end else if (adel_i) begin
            exc_code    = EXC_ADEL;
            exc_badaddr = 1'b1;
        end else if (ades_i) begin
            exc_code    = EXC_ADES;
            exc_badaddr = 1'b1;
        end else begin
            exc_take = 1'b0;
        end
    end

    assign flush_o  = exc_take | eret_i;
    assign new_pc_o = exc_take ? EXC_VECTOR : (eret_i ? epc_q : 32'd0);
    // An mtc0 that coincides with an exception or ERET never commits
    assign wr_ok    = wr_en_i & ~exc_take & ~eret_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exccode_q  <= EXC_INT;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            ip_hw_q <= hw_ext;
            if (exc_take) begin
                exccode_q <= exc_code;
                if (!status_q[ST_EXL]) begin
                    epc_q            <= delayslot_i ? (pc_i - 32'd4) : pc_i;
                    bd_q             <= delayslot_i;
                    status_q[ST_EXL] <= 1'b1;
                end
                if (exc_badaddr)
                    badvaddr_q <= badvaddr_i;
            end else if (eret_i) begin
                status_q[ST_EXL] <= 1'b0;
            end else if (wr_en_i) begin
                case (wr_addr_i)
                    REG_STATUS: status_q <= (status_q & ~STATUS_WR_MASK) | (wr_data_i & STATUS_WR_MASK);
                    REG_CAUSE:  ip_sw_q  <= wr_data_i[9:8];
                    REG_EPC:    epc_q    <= wr_data_i;
                    default:    ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
`endif

    assign status_o = status_q;
    assign cause_o  = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};
    assign epc_o    = epc_q;

    always_comb begin
        rd_data_o = 32'd0;
        case (rd_addr_i)
            REG_BADVADDR: rd_data_o = badvaddr_q;
            REG_COUNT:    rd_data_o = count;
            REG_COMPARE:  rd_data_o = compare;
            REG_STATUS:   rd_data_o = status_q;
            REG_CAUSE:    rd_data_o = cause_o;
            REG_EPC:      rd_data_o = epc_q;
            default:      rd_data_o = 32'd0;
        endcase
    end

endmodule
